// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 load/store unit.
package msrv32_pkg;

  localparam int unsigned XLEN = 32;

  // RV32I load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StResp  = 2'd2,
    StFault = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/msrv32_lsu_align.sv
// Combinational lane steering: request classification and store lanes, plus load extraction.
module msrv32_lsu_align
  import msrv32_pkg::*;
(
  input  logic [1:0]  req_addr_i,
  input  logic [2:0]  req_funct3_i,
  input  logic        req_is_store_i,
  input  logic [31:0] req_rs2_i,
  output logic [3:0]  req_wmask_o,
  output logic [31:0] req_wdata_o,
  output logic        req_misaligned_o,
  output logic        req_illegal_o,
  input  logic [1:0]  ld_addr_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic        legal;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    legal       = 1'b0;
    is_half     = 1'b0;
    is_word     = 1'b0;
    req_wmask_o = 4'b0000;
    req_wdata_o = 32'h0;
    case (req_funct3_i)
      F3_B:    legal = 1'b1;
      F3_H:    begin legal = 1'b1; is_half = 1'b1; end
      F3_W:    begin legal = 1'b1; is_word = 1'b1; end
      F3_BU:   legal = !req_is_store_i;
      F3_HU:   begin legal = !req_is_store_i; is_half = 1'b1; end
      default: legal = 1'b0;
    endcase
    // Size-based misalignment wins over an illegal code on the same request
    misaligned       = (is_half & req_addr_i[0]) | (is_word & (|req_addr_i));
    req_misaligned_o = misaligned;
    req_illegal_o    = !legal && !misaligned;
    if (req_is_store_i) begin
      case (req_funct3_i)
        F3_B: begin
          req_wmask_o = 4'b0001 << req_addr_i;
          req_wdata_o = {4{req_rs2_i[7:0]}};
        end
        F3_H: begin
          req_wmask_o = 4'b0011 << req_addr_i;
          req_wdata_o = {2{req_rs2_i[15:0]}};
        end
        F3_W: begin
          req_wmask_o = 4'b1111;
          req_wdata_o = req_rs2_i;
        end
        default: begin
          req_wmask_o = 4'b0000;
          req_wdata_o = 32'h0;
        end
      endcase
    end
  end

  always_comb begin
    shifted = ld_rdata_i >> {ld_addr_i, 3'b000};
    ld_byte = shifted[7:0];
    ld_half = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data_o = ld_rdata_i;
      F3_BU:   ld_data_o = {24'h0, ld_byte};
      F3_HU:   ld_data_o = {16'h0, ld_half};
      default: ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/msrv32_lsu.sv
// Load/store unit: alignment check, req/ack data-bus handshake, extended load writeback.
// Define MSRV32_LSU_TIMEOUT_EN to abort bus waits after TIMEOUT_CYCLES with bus_err_out.
module msrv32_lsu #(
  parameter int unsigned XLEN           = msrv32_pkg::XLEN,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_n_in,
  input  logic            lsu_valid_in,
  output logic            lsu_ready_out,
  input  logic            is_store_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] iadder_in,
  input  logic [XLEN-1:0] rs2_in,
  output logic            dmem_req_out,
  output logic            dmem_we_out,
  output logic [XLEN-1:0] dmem_addr_out,
  output logic [XLEN-1:0] dmem_wdata_out,
  output logic [3:0]      dmem_wmask_out,
  input  logic            dmem_ack_in,
  input  logic [XLEN-1:0] dmem_rdata_in,
  output logic            rd_valid_out,
  output logic [XLEN-1:0] rd_data_out,
  output logic            done_out,
  output logic            misaligned_out,
  output logic            illegal_out,
  output logic [XLEN-1:0] trap_addr_out,
  output logic            bus_err_out
);
  import msrv32_pkg::*;

  lsu_state_e      state_q;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      funct3_q;
  logic            we_q;
  logic [3:0]      wmask_q;
  logic [XLEN-1:0] wdata_q;
  logic            req_q;
  logic [XLEN-1:0] rd_data_q;
  logic [XLEN-1:0] trap_addr_q;
  logic            done_q;
  logic            rd_valid_q;
  logic            misaligned_q;
  logic            illegal_q;
  logic            bus_err_q;

  logic [3:0]      req_wmask;
  logic [31:0]     req_wdata;
  logic            req_misaligned;
  logic            req_illegal;
  logic [31:0]     ld_data;

`ifdef MSRV32_LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  msrv32_lsu_align u_align (
    .req_addr_i       (iadder_in[1:0]),
    .req_funct3_i     (funct3_in),
    .req_is_store_i   (is_store_in),
    .req_rs2_i        (rs2_in),
    .req_wmask_o      (req_wmask),
    .req_wdata_o      (req_wdata),
    .req_misaligned_o (req_misaligned),
    .req_illegal_o    (req_illegal),
    .ld_addr_i        (addr_q[1:0]),
    .ld_funct3_i      (funct3_q),
    .ld_rdata_i       (dmem_rdata_in),
    .ld_data_o        (ld_data)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      funct3_q     <= 3'b000;
      we_q         <= 1'b0;
      wmask_q      <= 4'b0000;
      wdata_q      <= '0;
      req_q        <= 1'b0;
      rd_data_q    <= '0;
      trap_addr_q  <= '0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      bus_err_q    <= 1'b0;
`ifdef MSRV32_LSU_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      bus_err_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (lsu_valid_in) begin
            if (req_misaligned || req_illegal) begin
              trap_addr_q  <= iadder_in;
              done_q       <= 1'b1;
              misaligned_q <= req_misaligned;
              illegal_q    <= req_illegal;
              state_q      <= StFault;
            end else begin
              addr_q   <= iadder_in;
              funct3_q <= funct3_in;
              we_q     <= is_store_in;
              wmask_q  <= req_wmask;
              wdata_q  <= req_wdata;
              req_q    <= 1'b1;
`ifdef MSRV32_LSU_TIMEOUT_EN
              cnt_q    <= '0;
`endif
              state_q  <= StReq;
            end
          end
        end
        StReq: begin
          if (dmem_ack_in) begin
            req_q  <= 1'b0;
            done_q <= 1'b1;
            if (!we_q) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= ld_data;
            end
            state_q <= StResp;
          end
`ifdef MSRV32_LSU_TIMEOUT_EN
          // Final no-ack cycle of the budget aborts; an ack in that cycle completes above
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            req_q       <= 1'b0;
            done_q      <= 1'b1;
            bus_err_q   <= 1'b1;
            trap_addr_q <= addr_q;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StResp:  state_q <= StIdle;
        StFault: state_q <= StIdle;
      endcase
    end
  end

  assign lsu_ready_out  = (state_q == StIdle);
  assign dmem_req_out   = req_q;
  assign dmem_we_out    = we_q;
  assign dmem_addr_out  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_wdata_out = wdata_q;
  assign dmem_wmask_out = wmask_q;
  assign rd_valid_out   = rd_valid_q;
  assign rd_data_out    = rd_data_q;
  assign done_out       = done_q;
  assign misaligned_out = misaligned_q;
  assign illegal_out    = illegal_q;
  assign trap_addr_out  = trap_addr_q;
  assign bus_err_out    = bus_err_q;

endmodule

// File: tb/tb_msrv32_lsu.sv
// Directed bench for msrv32_lsu: stores, loads, faults, async reset, optional bus timeout.
module tb_msrv32_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'h0;

  logic        ready, req, we, rd_valid, done, mis, ill, bus_err;
  logic [31:0] dm_addr, wdata, rd_data, trap_addr;
  logic [3:0]  wmask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv32_lsu #(
    .XLEN           (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .lsu_valid_in           (valid),
    .lsu_ready_out          (ready),
    .is_store_in            (is_store),
    .funct3_in              (f3),
    .iadder_in              (addr),
    .rs2_in                 (rs2),
    .dmem_req_out           (req),
    .dmem_we_out            (we),
    .dmem_addr_out          (dm_addr),
    .dmem_wdata_out         (wdata),
    .dmem_wmask_out         (wmask),
    .dmem_ack_in            (ack),
    .dmem_rdata_in          (rdata),
    .rd_valid_out           (rd_valid),
    .rd_data_out            (rd_data),
    .done_out               (done),
    .misaligned_out         (mis),
    .illegal_out            (ill),
    .trap_addr_out          (trap_addr),
    .bus_err_out            (bus_err)
  );

  // Present one request for a single cycle; returns at the negedge after the accepting edge.
  task automatic start(input logic st, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1; is_store = st; f3 = fn; addr = a; rs2 = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({req, we, done, rd_valid, mis, ill, bus_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000", {req, we, done, rd_valid, mis, ill, bus_err});
    end
    checks++;
    if ({dm_addr, wdata, rd_data, trap_addr, wmask} !== 132'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h %b want all zero",
               dm_addr, wdata, rd_data, trap_addr, wmask);
    end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_word;
    start(1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF);
    checks++;
    if ({req, we, ready} !== 3'b110) begin
      errors++; $display("FAIL sw_req got req/we/ready %b want 110", {req, we, ready});
    end
    checks++;
    if ({dm_addr, wmask, wdata} !== {32'h0000_1004, 4'b1111, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL sw_bus got %h %b %h want 00001004 1111 deadbeef", dm_addr, wmask, wdata);
    end
    @(negedge clk);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL sw_req_held got %b want 1", req); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if ({req, done, rd_valid, bus_err} !== 4'b0100) begin
      errors++;
      $display("FAIL sw_done got req/done/rdv/berr %b want 0100", {req, done, rd_valid, bus_err});
    end
    @(negedge clk);
    checks++;
    if ({ready, done} !== 2'b10) begin
      errors++; $display("FAIL sw_idle got ready/done %b want 10", {ready, done});
    end
  endtask

  task automatic test_store_lanes;
    start(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
    checks++;
    if ({dm_addr, wmask, wdata} !== {32'h0000_1000, 4'b1000, 32'hA5A5_A5A5}) begin
      errors++;
      $display("FAIL sb_lanes got %h %b %h want 00001000 1000 a5a5a5a5", dm_addr, wmask, wdata);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if ({done, rd_valid} !== 2'b10) begin
      errors++; $display("FAIL sb_done got %b want 10", {done, rd_valid});
    end
    start(1'b1, 3'b001, 32'h0000_1002, 32'h0000_1234);
    checks++;
    if ({dm_addr, wmask, wdata} !== {32'h0000_1000, 4'b1100, 32'h1234_1234}) begin
      errors++;
      $display("FAIL sh_lanes got %h %b %h want 00001000 1100 12341234", dm_addr, wmask, wdata);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loads;
    logic [2:0]  t_f3   [3] = '{3'b000, 3'b100, 3'b101};
    logic [31:0] t_addr [3] = '{32'h0000_2001, 32'h0000_2001, 32'h0000_2002};
    logic [31:0] t_rd   [3] = '{32'h0000_8000, 32'h0000_8000, 32'hBEEF_0000};
    logic [31:0] t_exp  [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF};
    logic [31:0] t_word [3] = '{32'h0000_2000, 32'h0000_2000, 32'h0000_2000};
    for (int i = 0; i < 3; i++) begin
      start(1'b0, t_f3[i], t_addr[i], 32'hFFFF_FFFF);
      checks++;
      if ({req, we, wmask, dm_addr} !== {2'b10, 4'b0000, t_word[i]}) begin
        errors++;
        $display("FAIL load%0d_bus got req/we %b mask %b addr %h want 10 0000 %h",
                 i, {req, we}, wmask, dm_addr, t_word[i]);
      end
      rdata = t_rd[i];
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      rdata = 32'h0;
      checks++;
      if ({done, rd_valid, bus_err, rd_data} !== {3'b110, t_exp[i]}) begin
        errors++;
        $display("FAIL load%0d_data got done/rdv/berr %b data %h want 110 %h",
                 i, {done, rd_valid, bus_err}, rd_data, t_exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_faults;
    start(1'b0, 3'b010, 32'h0000_3002, 32'h0);
    checks++;
    if ({done, mis, ill, req, rd_valid, trap_addr} !== {5'b11000, 32'h0000_3002}) begin
      errors++;
      $display("FAIL lw_misaligned got done/mis/ill/req/rdv %b trap %h want 11000 00003002",
               {done, mis, ill, req, rd_valid}, trap_addr);
    end
    @(negedge clk);
    checks++;
    if ({ready, req, mis, done} !== 4'b1000) begin
      errors++; $display("FAIL mis_after got %b want 1000", {ready, req, mis, done});
    end
    start(1'b0, 3'b011, 32'h0000_5000, 32'h0);
    checks++;
    if ({done, mis, ill, req, trap_addr} !== {4'b1010, 32'h0000_5000}) begin
      errors++;
      $display("FAIL illegal got done/mis/ill/req %b trap %h want 1010 00005000",
               {done, mis, ill, req}, trap_addr);
    end
    // Unsupported store code on an odd address reports misaligned only
    start(1'b1, 3'b101, 32'h0000_6001, 32'h0);
    checks++;
    if ({done, mis, ill, req, trap_addr} !== {4'b1100, 32'h0000_6001}) begin
      errors++;
      $display("FAIL priority got done/mis/ill/req %b trap %h want 1100 00006001",
               {done, mis, ill, req}, trap_addr);
    end
    @(negedge clk);
    checks++;
    if (rd_data !== 32'h0000_BEEF) begin
      errors++; $display("FAIL rd_hold got %h want 0000beef", rd_data);
    end
  endtask

  task automatic test_reset_mid;
    start(1'b1, 3'b010, 32'h0000_7000, 32'h1111_2222);
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL mid_req got %b want 1", req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req, done, rd_valid, ready} !== 4'b0001) begin
      errors++;
      $display("FAIL async_drop got req/done/rdv/ready %b want 0001", {req, done, rd_valid, ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({rd_data, trap_addr} !== 64'h0) begin
      errors++; $display("FAIL mid_regs got %h %h want 0 0", rd_data, trap_addr);
    end
    start(1'b0, 3'b100, 32'h0000_7001, 32'h0);
    rdata = 32'h0000_AB00;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    rdata = 32'h0;
    checks++;
    if ({done, rd_valid, rd_data} !== {2'b11, 32'h0000_00AB}) begin
      errors++;
      $display("FAIL post_reset got done/rdv %b data %h want 11 000000ab", {done, rd_valid}, rd_data);
    end
    @(negedge clk);
  endtask

`ifdef MSRV32_LSU_TIMEOUT_EN
  task automatic test_timeout;
    int n = 0;
    start(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    while (req === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL timeout_len got %0d want 4", n); end
    checks++;
    if ({bus_err, done, rd_valid, trap_addr} !== {3'b110, 32'h0000_4000}) begin
      errors++;
      $display("FAIL timeout_pulse got berr/done/rdv %b trap %h want 110 00004000",
               {bus_err, done, rd_valid}, trap_addr);
    end
    @(negedge clk);
    checks++;
    if ({ready, bus_err} !== 2'b10) begin
      errors++; $display("FAIL timeout_idle got %b want 10", {ready, bus_err});
    end
  endtask
`endif

  initial begin
    test_reset;
    test_store_word;
    test_store_lanes;
    test_loads;
    test_faults;
    test_reset_mid;
`ifdef MSRV32_LSU_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_lsu.md
Name: msrv32_lsu

Overview:
- Load/store unit that consumes the effective address produced by the immediate adder (iadder_out = rs1+imm) and drives the data-memory bus.
- Checks alignment and steers byte lanes, then runs a req/ack bus handshake and returns sign- or zero-extended load data to writeback.
- Sits between the execute stage and the data memory.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.
- TIMEOUT_CYCLES, 16, number of bus-wait cycles before abort; used only with MSRV32_LSU_TIMEOUT_EN.

Ports:
- ms_riscv32_mp_clk_in  input  1  clock, rising edge
- ms_riscv32_mp_rst_n_in  input  1  asynchronous active-low reset
- lsu_valid_in  input  1  request valid, sampled only when lsu_ready_out=1
- lsu_ready_out  output  1  unit idle, can accept a request
- is_store_in  input  1  1 = store, 0 = load
- funct3_in  input  3  RV32I width/sign code
- iadder_in  input  32  effective byte address
- rs2_in  input  32  store data
- dmem_req_out  output  1  bus request
- dmem_we_out  output  1  bus write enable
- dmem_addr_out  output  32  word address, bits[1:0] forced to 0
- dmem_wdata_out  output  32  lane-replicated store data
- dmem_wmask_out  output  4  byte-lane strobes
- dmem_ack_in  input  1  bus completion
- dmem_rdata_in  input  32  bus read word
- rd_valid_out  output  1  one-cycle pulse: load result valid
- rd_data_out  output  32  extended load result
- done_out  output  1  one-cycle pulse: any access completed, including faults
- misaligned_out  output  1  one-cycle pulse: alignment fault
- illegal_out  output  1  one-cycle pulse: unsupported funct3
- trap_addr_out  output  32  faulting byte address, held until the next fault
- bus_err_out  output  1  one-cycle pulse: bus timeout

Behaviour:
- Reset state:
  - FSM goes to IDLE.
  - dmem_req_out, dmem_we_out, all pulse outputs are 0.
  - dmem_addr_out, dmem_wdata_out, dmem_wmask_out, rd_data_out, trap_addr_out are 0.
  - Reset asserted mid-transaction drops dmem_req_out immediately (asynchronously); the access is discarded with no pulses.
- FSM states: IDLE, REQ, RESP, FAULT.
- IDLE:
  - lsu_ready_out=1.
  - On lsu_valid_in: classify funct3.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - Illegal or misaligned request -> FAULT: capture trap_addr_out=iadder_in; no bus activity.
  - Otherwise register dmem_addr_out, dmem_we_out, dmem_wmask_out, dmem_wdata_out and go to REQ.
- REQ:
  - dmem_req_out=1 with all bus outputs stable until dmem_ack_in is sampled high.
  - On ack: latch the extended load result into rd_data_out, then go to RESP.
  - Minimum latency is accept at edge N, req high in cycle N+1, ack in N+1, RESP in N+2.
- RESP:
  - done_out=1; rd_valid_out=1 for loads only.
  - Return to IDLE; lsu_ready_out=1 in the following cycle, so back-to-back throughput is one access per 3 cycles.
- FAULT: pulse done_out plus exactly one of misaligned_out or illegal_out (misaligned takes priority if both apply), then return to IDLE.
- dmem_ack_in outside REQ is ignored; lsu_valid_in outside IDLE is ignored.
- Store lane steering:
  - SB: mask = 0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: mask = 0011<<addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: mask 1111, wdata = rs2.
- Loads: mask driven 0000. Byte lane selected by addr[1:0]; halfword lane selected by addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- rd_data_out holds its value until the next load completes.

Optional Feature:
- MSRV32_LSU_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - At TIMEOUT_CYCLES, drop dmem_req_out, set trap_addr_out = the request's byte address, pulse bus_err_out and done_out (no rd_valid_out), and return to IDLE.
  - Ack arriving in the same cycle as the limit wins: normal completion.
- Macro undefined: no counter; REQ waits indefinitely; bus_err_out tied 0.

Decomposition:
- Package msrv32_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - LSU state encoding localparams.
  - XLEN.
- Sub-module msrv32_lsu_align (combinational):
  - Store side: addr[1:0], funct3, rs2 -> wmask, wdata, misaligned, illegal.
  - Load side: addr[1:0], funct3, rdata -> extended result.
- msrv32_lsu holds the FSM, registers and timeout counter.

Test Plan:
- SW addr 0x0000_1004, rs2 0xDEADBEEF, ack 2 cycles after req -> dmem_addr 0x1004, wmask 1111, wdata 0xDEADBEEF, req held 2 cycles, done_out pulse, no rd_valid_out.
- SB addr 0x1003, rs2 0x0000_00A5 -> wmask 1000, wdata 0xA5A5A5A5. SH addr 0x1002, rs2 0x1234 -> wmask 1100, wdata 0x12341234.
- LB addr 0x2001, rdata 0x0000_8000 -> rd_data 0xFFFF_FF80. LBU same -> 0x0000_0080. LHU addr 0x2002, rdata 0xBEEF_0000 -> 0x0000_BEEF.
- LW addr 0x3002 -> misaligned_out pulse, trap_addr 0x3002, dmem_req never asserted. funct3=011 load -> illegal_out pulse.
- Reset low while in REQ -> dmem_req_out falls without a clock edge; after release, a new request completes normally.
- With MSRV32_LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, ack never returned -> bus_err_out pulse after 4 REQ cycles, FSM back to IDLE.
